// File: rtl/gcd_farm.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_farm
//  Purpose  : Multi-engine subtractive GCD accelerator. Jobs are issued
//             round-robin into N engines, one per cycle. Results are returned
//             strictly in issue order on a single q/rdy port. ovf is a sticky
//             flag that records any dropped job.
//  Revision : 1.0  initial release
// ============================================================================
module gcd_farm #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    input  logic                   ld,
    output logic                   busy,
    output logic [W-1:0]           q,
    output logic                   rdy,
    output logic                   ovf,
    output logic [$clog2(N+1)-1:0] inflight
);

    localparam int              c_PW   = $clog2(N);
    localparam int              c_CW   = $clog2(N+1);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(N-1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Per-engine state and result, gathered from the engine instances
    logic [1:0]      w_st  [N];
    logic [W-1:0]    w_res [N];

    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [W-1:0]    r_q;
    logic            r_rdy;
    logic            r_ovf;
    logic [c_CW-1:0] r_inflight;

    logic            w_busy;
    logic            w_acc;
    logic            w_dlv;

    // busy depends only on the registered state of the engine at tail, so an
    // engine freed on this edge can take a new job on the following edge
    assign w_busy = (w_st[r_tail] != c_IDLE);
    assign w_acc  = ld & ~w_busy;
    assign w_dlv  = (w_st[r_head] == c_DONE);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_eng
            localparam logic [c_PW-1:0] c_ID = c_PW'(gi);

            logic [1:0]   r_st;
            logic [W-1:0] r_x;
            logic [W-1:0] r_y;
            logic [W-1:0] r_res;

            // Engine FSM: load on issue, subtract until done, then hold the
            // result until the head pointer collects it
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_st  <= c_IDLE;
                    r_x   <= '0;
                    r_y   <= '0;
                    r_res <= '0;
                end else begin
                    case (r_st)
                        c_IDLE: begin
                            if (w_acc && (r_tail == c_ID)) begin
                                r_x  <= a;
                                r_y  <= b;
                                r_st <= c_RUN;
                            end
                        end
                        c_RUN: begin
                            if (r_x == '0) begin
                                r_res <= r_y;
                                r_st  <= c_DONE;
                            end else if (r_y == '0) begin
                                r_res <= r_x;
                                r_st  <= c_DONE;
                            end else if (r_x == r_y) begin
                                r_res <= r_x;
                                r_st  <= c_DONE;
                            end else if (r_x > r_y) begin
                                r_x <= r_x - r_y;
                            end else begin
                                r_y <= r_y - r_x;
                            end
                        end
                        c_DONE: begin
                            if (w_dlv && (r_head == c_ID)) begin
                                r_st <= c_IDLE;
                            end
                        end
                        default: r_st <= c_IDLE;
                    endcase
                end
            end

            assign w_st[gi]  = r_st;
            assign w_res[gi] = r_res;
        end
    endgenerate

    // Issue/delivery pointers, in-order output register, overrun flag and
    // occupancy counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_q        <= '0;
            r_rdy      <= 1'b0;
            r_ovf      <= 1'b0;
            r_inflight <= '0;
        end else begin
            if (w_acc) begin
                r_tail <= (r_tail == c_LAST) ? '0 : r_tail + 1'b1;
            end
            if (ld && w_busy) begin
                r_ovf <= 1'b1;
            end
            if (w_dlv) begin
                r_q    <= w_res[r_head];
                r_rdy  <= 1'b1;
                r_head <= (r_head == c_LAST) ? '0 : r_head + 1'b1;
            end else begin
                r_rdy  <= 1'b0;
            end
            case ({w_acc, w_dlv})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign busy     = w_busy;
    assign q        = r_q;
    assign rdy      = r_rdy;
    assign ovf      = r_ovf;
    assign inflight = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_gcd_farm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_farm
//  Purpose  : Directed self-checking bench for gcd_farm. One instance uses
//             W=8/N=4 and a second uses W=16/N=3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gcd_farm;

    logic        clk;
    logic        reset;

    logic [7:0]  a0, b0, q0;
    logic        ld0, busy0, rdy0, ovf0;
    logic [2:0]  inflight0;

    logic [15:0] a1, b1, q1;
    logic        ld1, busy1, rdy1, ovf1;
    logic [1:0]  inflight1;

    int n_chk;
    int n_err;

    // Edge index relative to the current test's first issue edge (E0),
    // plus a log of every rdy pulse seen on the W=8 instance
    int          e;
    int          nev;
    int          ev_e [16];
    logic [7:0]  ev_q [16];
    logic        ev_b [16];

    gcd_farm #(.W(8), .N(4)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .a        (a0),
        .b        (b0),
        .ld       (ld0),
        .busy     (busy0),
        .q        (q0),
        .rdy      (rdy0),
        .ovf      (ovf0),
        .inflight (inflight0)
    );

    gcd_farm #(.W(16), .N(3)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .a        (a1),
        .b        (b1),
        .ld       (ld1),
        .busy     (busy1),
        .q        (q1),
        .rdy      (rdy1),
        .ovf      (ovf1),
        .inflight (inflight1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_log();
        e   = -1;
        nev = 0;
    endtask

    // One rising edge, then sample 1 time unit later and log any delivery
    task automatic step();
        @(posedge clk);
        #1;
        e++;
        if (rdy0 && nev < 16) begin
            ev_e[nev] = e;
            ev_q[nev] = q0;
            ev_b[nev] = busy0;
            nev++;
        end
    endtask

    // Reference subtraction-step count for the latency expectation
    function automatic int sub_steps(input int x, input int y);
        int s;
        s = 0;
        while (x != 0 && y != 0 && x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
            s++;
        end
        return s;
    endfunction

    // Issue one job on the W=16 instance and wait (bounded) for its result
    task automatic job16(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] exp_q);
        int lat;
        a1 = va; b1 = vb; ld1 = 1'b1;
        step();
        ld1 = 1'b0;
        lat = 0;
        while (!rdy1 && lat < 300) begin
            step();
            lat++;
        end
        check("w16_rdy", rdy1, 1);
        check("w16_q", q1, exp_q);
        check("w16_lat", lat, 2 + sub_steps(va, vb));
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        reset = 1'b1;
        a0 = '0; b0 = '0; ld0 = 1'b0;
        a1 = '0; b1 = '0; ld1 = 1'b0;
        clear_log();

        // Reset state
        step(); step();
        reset = 1'b0;
        check("rst_q", q0, 0);
        check("rst_rdy", rdy0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_inflight", inflight0, 0);
        check("rst_busy", busy0, 0);
        check("rst_busy16", busy1, 0);

        // Single job gcd(12,8)=4, delivered after E4
        clear_log();
        a0 = 8'd12; b0 = 8'd8; ld0 = 1'b1;
        step();
        ld0 = 1'b0;
        check("s1_inflight1", inflight0, 1);
        check("s1_rdy_e0", rdy0, 0);
        repeat (3) step();
        check("s1_rdy_e3", rdy0, 0);
        step();
        check("s1_rdy_e4", rdy0, 1);
        check("s1_q", q0, 4);
        check("s1_inflight0", inflight0, 0);
        step();
        check("s1_rdy_e5", rdy0, 0);

        // gcd(12,12)=12, delivered after E2
        clear_log();
        a0 = 8'd12; b0 = 8'd12; ld0 = 1'b1;
        step();
        ld0 = 1'b0;
        step();
        check("s2_rdy_e1", rdy0, 0);
        step();
        check("s2_rdy_e2", rdy0, 1);
        check("s2_q", q0, 12);

        // In-order delivery: slow job first, fast job held behind it
        step(); step();
        clear_log();
        a0 = 8'd255; b0 = 8'd1; ld0 = 1'b1;
        step();
        a0 = 8'd6; b0 = 8'd6;
        step();
        ld0 = 1'b0;
        while (e < 260) step();
        check("ord_count", nev, 2);
        check("ord_e0", ev_e[0], 256);
        check("ord_q0", ev_q[0], 1);
        check("ord_e1", ev_e[1], 257);
        check("ord_q1", ev_q[1], 6);

        // Full farm and overrun
        clear_log();
        a0 = 8'd200; b0 = 8'd1; ld0 = 1'b1;
        repeat (4) step();
        check("full_busy", busy0, 1);
        check("full_inflight", inflight0, 4);
        check("full_ovf_pre", ovf0, 0);
        a0 = 8'd5; b0 = 8'd5;
        step();
        ld0 = 1'b0;
        check("ovf_set", ovf0, 1);
        check("ovf_inflight", inflight0, 4);
        while (e < 210) step();
        check("full_count", nev, 4);
        check("full_first_e", ev_e[0], 201);
        check("full_last_e", ev_e[3], 204);
        check("full_q0", ev_q[0], 1);
        check("full_q3", ev_q[3], 1);
        check("full_busy_drop", ev_b[0], 0);
        check("full_inflight_end", inflight0, 0);
        check("ovf_sticky", ovf0, 1);

        // Zero operands, back-to-back
        clear_log();
        a0 = 8'd0; b0 = 8'd0; ld0 = 1'b1;
        step();
        a0 = 8'd0; b0 = 8'd9;
        step();
        a0 = 8'd9; b0 = 8'd0;
        step();
        ld0 = 1'b0;
        while (e < 8) step();
        check("zero_count", nev, 3);
        check("zero_e0", ev_e[0], 2);
        check("zero_e2", ev_e[2], 4);
        check("zero_q0", ev_q[0], 0);
        check("zero_q1", ev_q[1], 9);
        check("zero_q2", ev_q[2], 9);

        // Reset with three jobs in flight
        clear_log();
        a0 = 8'd200; b0 = 8'd1; ld0 = 1'b1;
        repeat (3) step();
        ld0 = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_q", q0, 0);
        check("mid_rdy", rdy0, 0);
        check("mid_ovf", ovf0, 0);
        check("mid_inflight", inflight0, 0);
        check("mid_busy", busy0, 0);
        clear_log();
        while (e < 210) step();
        check("mid_no_rdy", nev, 0);
        clear_log();
        a0 = 8'd21; b0 = 8'd14; ld0 = 1'b1;
        step();
        ld0 = 1'b0;
        while (e < 6) step();
        check("post_count", nev, 1);
        check("post_e", ev_e[0], 4);
        check("post_q", ev_q[0], 7);
        check("post_head", dut0.r_head, 1);

        // W=16, N=3: seven sequential jobs wrap the pointers twice
        job16(16'd48000, 16'd18000, 16'd6000);
        job16(16'd10, 16'd4, 16'd2);
        job16(16'd9, 16'd6, 16'd3);
        job16(16'd7, 16'd7, 16'd7);
        job16(16'd100, 16'd75, 16'd25);
        job16(16'd0, 16'd5, 16'd5);
        job16(16'd17, 16'd5, 16'd1);
        check("w16_tail", dut1.r_tail, 1);
        check("w16_inflight", inflight1, 0);
        check("w16_ovf", ovf1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
